// File: rtl/router_fsm_ctrl.sv
// Packet-level controller for the 1x3 router input path: decodes the header
// destination and sequences header, payload and parity writes into the selected FIFO.
module router_fsm_ctrl #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              busy,
  output logic              detect_add,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              lfd_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg
);

  // state              | meaning
  // S_DECODE_ADDRESS   | idle, waiting for a header with a valid destination
  // S_LOAD_FIRST_DATA  | header byte written to FIFO (lfd flag set)
  // S_LOAD_DATA        | payload bytes streaming into FIFO
  // S_FIFO_FULL        | selected FIFO full, source held off
  // S_LOAD_AFTER_FULL  | write the byte held during the full stall
  // S_LOAD_PARITY      | parity byte written
  // S_CHECK_PARITY_ERR | register block compares parity, clears error reg
  // S_WAIT_TILL_EMPTY  | destination busy, waiting for it to drain
  localparam logic [2:0] S_DECODE_ADDRESS   = 3'd0;
  localparam logic [2:0] S_LOAD_FIRST_DATA  = 3'd1;
  localparam logic [2:0] S_LOAD_DATA        = 3'd2;
  localparam logic [2:0] S_FIFO_FULL        = 3'd3;
  localparam logic [2:0] S_LOAD_AFTER_FULL  = 3'd4;
  localparam logic [2:0] S_LOAD_PARITY      = 3'd5;
  localparam logic [2:0] S_CHECK_PARITY_ERR = 3'd6;
  localparam logic [2:0] S_WAIT_TILL_EMPTY  = 3'd7;

  localparam logic [ADDR_W-1:0] ADDR_0   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_1   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_2   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_INV = ADDR_W'(3);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_ok;
  logic              empty_hdr;
  logic              empty_sel;
  logic              soft_sel;

  assign addr_ok = (data_in != ADDR_INV);

  // Header decode looks at the live address; everything later uses the latched one.
  always_comb begin
    empty_hdr = 1'b0;
    if (data_in == ADDR_0)      empty_hdr = fifo_empty_0;
    else if (data_in == ADDR_1) empty_hdr = fifo_empty_1;
    else if (data_in == ADDR_2) empty_hdr = fifo_empty_2;
  end

  always_comb begin
    empty_sel = 1'b0;
    soft_sel  = 1'b0;
    if (addr_q == ADDR_0) begin
      empty_sel = fifo_empty_0;
      soft_sel  = soft_reset_0;
    end else if (addr_q == ADDR_1) begin
      empty_sel = fifo_empty_1;
      soft_sel  = soft_reset_1;
    end else if (addr_q == ADDR_2) begin
      empty_sel = fifo_empty_2;
      soft_sel  = soft_reset_2;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DECODE_ADDRESS: begin
        if (pkt_valid && addr_ok)
          state_d = empty_hdr ? S_LOAD_FIRST_DATA : S_WAIT_TILL_EMPTY;
      end
      S_LOAD_FIRST_DATA: state_d = S_LOAD_DATA;
      S_LOAD_DATA: begin
        if (fifo_full)       state_d = S_FIFO_FULL;
        else if (!pkt_valid) state_d = S_LOAD_PARITY;
      end
      S_FIFO_FULL: begin
        if (!fifo_full) state_d = S_LOAD_AFTER_FULL;
      end
      S_LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = S_DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = S_LOAD_PARITY;
        else                    state_d = S_LOAD_DATA;
      end
      S_LOAD_PARITY: state_d = S_CHECK_PARITY_ERR;
      S_CHECK_PARITY_ERR: state_d = fifo_full ? S_FIFO_FULL : S_DECODE_ADDRESS;
      S_WAIT_TILL_EMPTY: begin
        if (empty_sel) state_d = S_LOAD_FIRST_DATA;
      end
      default: state_d = S_DECODE_ADDRESS;
    endcase
    // A timeout on the selected FIFO aborts whatever packet is in flight.
    if (soft_sel) state_d = S_DECODE_ADDRESS;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE_ADDRESS && pkt_valid && addr_ok)
        addr_q <= data_in;
    end
  end

  assign detect_add    = (state_q == S_DECODE_ADDRESS);
  assign lfd_state     = (state_q == S_LOAD_FIRST_DATA);
  assign ld_state      = (state_q == S_LOAD_DATA);
  assign full_state    = (state_q == S_FIFO_FULL);
  assign laf_state     = (state_q == S_LOAD_AFTER_FULL);
  assign rst_int_reg   = (state_q == S_CHECK_PARITY_ERR);
  assign write_enb_reg = (state_q == S_LOAD_DATA) || (state_q == S_LOAD_PARITY) ||
                         (state_q == S_LOAD_AFTER_FULL);
  assign busy          = !((state_q == S_DECODE_ADDRESS) || (state_q == S_LOAD_DATA));

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Scoreboard bench for router_fsm_ctrl: each driven cycle pushes the expected
// output vector, a monitor pops and compares it just after the next rising edge.
module tb_router_fsm_ctrl;

  // Expected output vectors {busy, detect_add, lfd, ld, full, laf, rst_int, wen}
  localparam logic [7:0] E_DA  = 8'b0100_0000;
  localparam logic [7:0] E_LFD = 8'b1010_0000;
  localparam logic [7:0] E_LD  = 8'b0001_0001;
  localparam logic [7:0] E_FFS = 8'b1000_1000;
  localparam logic [7:0] E_LAF = 8'b1000_0101;
  localparam logic [7:0] E_LP  = 8'b1000_0001;
  localparam logic [7:0] E_CPE = 8'b1000_0010;
  localparam logic [7:0] E_WTE = 8'b1000_0000;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       busy, detect_add, ld_state, laf_state, full_state, lfd_state;
  logic       write_enb_reg, rst_int_reg;
  logic [7:0] outs;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];
  string      cur_tag = "init";

  router_fsm_ctrl #(.ADDR_W(2)) dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .busy(busy), .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .lfd_state(lfd_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg)
  );

  assign outs = {busy, detect_add, lfd_state, ld_state, full_state, laf_state,
                 rst_int_reg, write_enb_reg};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge with inputs already set; exp is the state after the next edge.
  task automatic step(input logic [7:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(cur_tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) chk(tag_q.pop_front(), {24'd0, outs}, {24'd0, exp_q.pop_front()});
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    #12;
    chk("reset_outs", {24'd0, outs}, {24'd0, E_DA});
    @(negedge clk);
    resetn = 1'b1;
    step(E_DA);

    // 1: normal packet to FIFO 1, three payload bytes
    cur_tag = "t1_pkt";
    pkt_valid = 1'b1; data_in = 2'd1;
    step(E_LFD);
    data_in = 2'd3;
    step(E_LD); step(E_LD); step(E_LD);
    pkt_valid = 1'b0;
    step(E_LP); step(E_CPE); step(E_DA); step(E_DA);

    // 2: destination 0 busy, wait for drain
    cur_tag = "t2_wait";
    fifo_empty_0 = 1'b0; pkt_valid = 1'b1; data_in = 2'd0;
    step(E_WTE);
    pkt_valid = 1'b0;
    for (int i = 0; i < 4; i++) step(E_WTE);
    fifo_empty_0 = 1'b1;
    step(E_LFD);
    pkt_valid = 1'b1;
    step(E_LD);

    // 3: full stall inside payload, resume into LD
    cur_tag = "t3_full";
    fifo_full = 1'b1;
    step(E_FFS); step(E_FFS); step(E_FFS);
    fifo_full = 1'b0;
    step(E_LAF);
    step(E_LD);

    // 4: stall then low_pkt_valid -> parity path; then CPE-full and parity_done exit
    cur_tag = "t4_lpv";
    fifo_full = 1'b1;
    step(E_FFS);
    fifo_full = 1'b0;
    step(E_LAF);
    low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    step(E_LP);
    low_pkt_valid = 1'b0;
    step(E_CPE);
    step(E_DA);
    cur_tag = "t4_cpe_full";
    pkt_valid = 1'b1; data_in = 2'd0;
    step(E_LFD);
    step(E_LD);
    pkt_valid = 1'b0;
    step(E_LP);
    fifo_full = 1'b1;
    step(E_CPE);
    step(E_FFS);
    fifo_full = 1'b0;
    step(E_LAF);
    cur_tag = "t4_pdone";
    parity_done = 1'b1; low_pkt_valid = 1'b1;
    step(E_DA);
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    step(E_DA);

    // 5: invalid address, then selective soft reset
    cur_tag = "t5_addr3";
    pkt_valid = 1'b1; data_in = 2'd3;
    step(E_DA); step(E_DA);
    cur_tag = "t5_soft";
    data_in = 2'd2;
    step(E_LFD);
    step(E_LD);
    soft_reset_0 = 1'b1;
    step(E_LD);
    soft_reset_0 = 1'b0; soft_reset_2 = 1'b1;
    step(E_DA);
    soft_reset_2 = 1'b0; pkt_valid = 1'b0;
    step(E_DA);

    // 6: asynchronous reset in the middle of a payload
    cur_tag = "t6_pre";
    pkt_valid = 1'b1; data_in = 2'd1;
    step(E_LFD);
    step(E_LD);
    #2 resetn = 1'b0;
    #1 chk("t6_async_rst", {24'd0, outs}, {24'd0, E_DA});
    @(negedge clk);
    chk("t6_held_rst", {24'd0, outs}, {24'd0, E_DA});
    resetn = 1'b1;
    cur_tag = "t6_after";
    data_in = 2'd2;
    step(E_LFD);
    step(E_LD);
    pkt_valid = 1'b0;
    step(E_LP); step(E_CPE); step(E_DA);

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/router_fsm_ctrl.md
Name: router_fsm_ctrl

Overview:
- Packet-level controller for the 1x3 router input path.
- Decodes the 2-bit destination in the header byte.
- Sequences header, payload and parity writes into the addressed output FIFO (16x9, holding an lfd flag plus a byte).
- Stalls on FIFO-full and waits for a busy destination to drain.
- Drives the register block (detect_add, ld/laf/full/lfd strobes, rst_int_reg) and busy back to the source.

Parameters:
- ADDR_W, 2, width of destination field taken from data_in[1:0]; encodings 0..2 valid, 3 invalid.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- pkt_valid  in  1  source asserts for header+payload bytes, deasserts on the parity byte
- data_in  in  2  header address bits, sampled in DECODE_ADDRESS
- fifo_full  in  1  full flag of the currently selected FIFO (muxed externally)
- fifo_empty_0/1/2  in  1 each  empty flags of FIFO 0/1/2
- soft_reset_0/1/2  in  1 each  per-FIFO timeout resets from the synchronizer
- parity_done  in  1  register block has captured parity
- low_pkt_valid  in  1  register block saw pkt_valid fall while stalled
- busy  out  1  source must hold data
- detect_add  out  1  register block latches header/address
- ld_state, laf_state, full_state, lfd_state  out  1 each  state strobes to register block
- write_enb_reg  out  1  write enable toward FIFO mux
- rst_int_reg  out  1  clear internal parity-error register

Behaviour:
- Moore FSM. One-hot or binary encoding is allowed. All outputs decode from the state register only.
- Reset (resetn=0, asynchronous): state=DECODE_ADDRESS, addr_q=0.
- Reset output values: detect_add=1, busy=0, all other outputs=0.
- addr_q captures data_in in DECODE_ADDRESS when pkt_valid=1 and data_in!=3.
- Transitions (evaluated each clk):
  - DECODE_ADDRESS:
    - pkt_valid & addr!=3 & fifo_empty_[addr] -> LOAD_FIRST_DATA.
    - pkt_valid & addr!=3 & !fifo_empty_[addr] -> WAIT_TILL_EMPTY.
    - Otherwise (including addr==3) stay.
  - LOAD_FIRST_DATA -> LOAD_DATA, unconditional.
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE (full has priority).
    - else !pkt_valid -> LOAD_PARITY.
    - else stay.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - else low_pkt_valid -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - WAIT_TILL_EMPTY: fifo_empty_[addr_q] -> LOAD_FIRST_DATA, else stay.
- Soft reset:
  - soft_reset_[addr_q]=1 in any state -> DECODE_ADDRESS next cycle. This overrides all other transitions.
  - Soft resets of non-selected FIFOs are ignored.
- Output decode:
  - detect_add = DECODE_ADDRESS.
  - lfd_state = LOAD_FIRST_DATA.
  - ld_state = LOAD_DATA.
  - full_state = FIFO_FULL_STATE.
  - laf_state = LOAD_AFTER_FULL.
  - rst_int_reg = CHECK_PARITY_ERROR.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Latency:
  - Header accepted in DECODE_ADDRESS at edge N.
  - lfd_state=1 during cycle N+1.
  - First payload write in cycle N+2.
  - Parity write one cycle after pkt_valid falls.
- Exactly one of detect_add/lfd/ld/full/laf/rst_int_reg is high at any time when the FSM is in a state that decodes one of them.
- Unused binary encodings recover to DECODE_ADDRESS.

Test Plan:
1. Header data_in=2'b01, fifo_empty_1=1, 3 payload bytes, then parity -> state sequence DA, LFD, LD, LD, LD, LP, CPE, DA. write_enb_reg high for 4 cycles. busy=1 only in LFD, LP and CPE.
2. Header addr=0 with fifo_empty_0=0 for 5 cycles -> stays in WAIT_TILL_EMPTY, busy=1. LFD is entered the cycle after fifo_empty_0 rises.
3. In LD, fifo_full=1 for 3 cycles with pkt_valid=1 -> FFS for 3 cycles (full_state=1, write_enb_reg=0), then LAF. With parity_done=0 and low_pkt_valid=0 -> LD.
4. FFS then LAF with low_pkt_valid=1 and parity_done=0 -> LP, CPE, DA. Repeat with parity_done=1 -> DA directly from LAF.
5. Header data_in=3 with pkt_valid=1 -> remains in DA, no write_enb_reg, busy=0. soft_reset_2 pulse while addr_q=2 in LD -> DA next cycle. soft_reset_0 in the same situation -> no effect.
6. resetn deasserted mid-LD (asynchronous, between edges) -> outputs return immediately to detect_add=1 and all others 0. After release, a new header is accepted normally.
